fft_iter_engine: RTL and testbench

Parametrised iterative radix-2 decimation-in-time FFT engine. It is the successor to the fixed 64-point butterfly array, and adds five things: configurable point count and data/twiddle widths, streaming load and unload with a valid/ready handshake, signed fixed-point arithmetic with per-stage scaling, and an explicit start/busy/done control FSM. It sits between the sample capture front-end and the spectral post-processing block, and performs one butterfly per clock on in-place storage.

---
 rtl/fft_pkg.sv | 86 ++++++++
 rtl/fft_iter_engine_if.sv | 25 ++
 rtl/fft_twiddle_rom.sv | 30 +++
 rtl/fft_iter_engine.sv | 240 ++++++++++++++++++++++++
 tb/tb_fft_iter_engine.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fft_pkg.sv
// Shared types and elaboration-time helpers for the iterative FFT engine.
package fft_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_COMPUTE = 2'd2,
        ST_UNLOAD  = 2'd3
    } fft_state_e;

    // Fixed-point format used only while building the twiddle tables.
    localparam int unsigned TW_FRAC_Q = 28;
    localparam longint      TW_ONE_Q  = 64'sd268435456;
    localparam longint      TW_PI_Q   = 64'sd843314857;

    // Reverse the low 'bits' bits of v.
    function automatic int unsigned bitrev(input int unsigned v, input int unsigned bits);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < bits; i++) begin
            r = (r << 1) | ((v >> i) & 32'd1);
        end
        return r;
    endfunction

    // cos or sin of 2*pi*k/n in Q28, k in [0, n/2); Taylor series on [0, pi/2].
    function automatic longint tw_sincos(input int unsigned k, input int unsigned n,
                                         input bit want_sin);
        longint      theta;
        longint      theta_sq;
        longint      term;
        longint      sum;
        longint      d;
        int unsigned kk;
        bit          flip;
        flip     = (k > n / 4);
        kk       = flip ? (n / 2 - k) : k;
        theta    = (longint'(2) * TW_PI_Q * longint'(kk)) / longint'(n);
        theta_sq = (theta * theta) >>> TW_FRAC_Q;
        term     = want_sin ? theta : TW_ONE_Q;
        sum      = term;
        for (int i = 1; i <= 10; i++) begin
            d    = want_sin ? longint'((2 * i) * (2 * i + 1)) : longint'((2 * i - 1) * (2 * i));
            term = -(((term * theta_sq) >>> TW_FRAC_Q) / d);
            sum  = sum + term;
        end
        if (flip && !want_sin) begin
            sum = -sum;
        end
        return sum;
    endfunction

    // Round a Q28 value to Q2.(tw_w-2).
    function automatic int tw_round(input longint v, input int unsigned tw_w);
        int unsigned sh;
        sh = TW_FRAC_Q - (tw_w - 2);
        return int'((v + (longint'(1) << (sh - 1))) >>> sh);
    endfunction

    // Real part of exp(-j*2*pi*k/n).
    function automatic int tw_re(input int unsigned k, input int unsigned n, input int unsigned tw_w);
        return tw_round(tw_sincos(k, n, 1'b0), tw_w);
    endfunction

    // Imaginary part of exp(-j*2*pi*k/n).
    function automatic int tw_im(input int unsigned k, input int unsigned n, input int unsigned tw_w);
        return -tw_round(tw_sincos(k, n, 1'b1), tw_w);
    endfunction

    // Clamp v to the w-bit signed range.
    function automatic longint sat(input longint v, input int unsigned w);
        longint hi;
        longint lo;
        longint r;
        hi = (longint'(1) << (w - 1)) - longint'(1);
        lo = -(longint'(1) << (w - 1));
        r  = v;
        if (v > hi) begin
            r = hi;
        end else if (v < lo) begin
            r = lo;
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_iter_engine_if.sv
// Streaming load/unload bus of the FFT engine (sample in, bin out).
interface fft_iter_engine_if #(
    parameter int unsigned DATA_W = 16
) ();

    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_re;
    logic signed [DATA_W-1:0] in_im;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [DATA_W-1:0] out_re;
    logic signed [DATA_W-1:0] out_im;

    modport master (
        output in_valid, in_re, in_im, out_ready,
        input  in_ready, out_valid, out_re, out_im
    );

    modport slave (
        input  in_valid, in_re, in_im, out_ready,
        output in_ready, out_valid, out_re, out_im
    );

endinterface

// File: rtl/fft_twiddle_rom.sv
// Combinational twiddle ROM: exp(-j*2*pi*k/N) for k in [0, N/2), Q2.(TW_W-2).
module fft_twiddle_rom
    import fft_pkg::*;
#(
    parameter int unsigned N_POINTS = 64,
    parameter int unsigned LOG2_N   = 6,
    parameter int unsigned TW_W     = 10
) (
    input  logic        [LOG2_N-2:0] idx,
    output logic signed [TW_W-1:0]   re,
    output logic signed [TW_W-1:0]   im
);

    localparam int unsigned HALF = N_POINTS / 2;

    logic signed [TW_W-1:0] tab_re [HALF];
    logic signed [TW_W-1:0] tab_im [HALF];

    // Table entries are folded to constants at elaboration.
    for (genvar i = 0; i < HALF; i++) begin : g_tab
        localparam logic signed [TW_W-1:0] RE_V = TW_W'(tw_re(i, N_POINTS, TW_W));
        localparam logic signed [TW_W-1:0] IM_V = TW_W'(tw_im(i, N_POINTS, TW_W));
        assign tab_re[i] = RE_V;
        assign tab_im[i] = IM_V;
    end

    assign re = tab_re[idx];
    assign im = tab_im[idx];

endmodule

// File: rtl/fft_iter_engine.sv
// Iterative radix-2 DIT FFT: bit-reversed streaming load, one in-place
// butterfly per clock with 1/2 scaling per stage, natural-order unload.
// Optional build macro FFT_INVERSE_EN adds the inv port (conjugated twiddles).
module fft_iter_engine
    import fft_pkg::*;
#(
    parameter int unsigned N_POINTS = 64,
    parameter int unsigned LOG2_N   = 6,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned TW_W     = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
`ifdef FFT_INVERSE_EN
    input  logic inv,
`endif
    output logic busy,
    output logic done,
    fft_iter_engine_if.slave bus
);

    localparam int unsigned ADDR_W = LOG2_N;
    localparam int unsigned TWI_W  = LOG2_N - 1;
    localparam int unsigned STG_W  = $clog2(LOG2_N);
    localparam int unsigned MUL_W  = DATA_W + TW_W + 1;
    localparam int unsigned T_W    = DATA_W + 1;
    localparam int unsigned SUM_W  = DATA_W + 2;

    localparam logic [1:0] IDLE    = ST_IDLE;
    localparam logic [1:0] LOAD    = ST_LOAD;
    localparam logic [1:0] COMPUTE = ST_COMPUTE;
    localparam logic [1:0] UNLOAD  = ST_UNLOAD;

    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(N_POINTS - 1);
    localparam logic [TWI_W-1:0]  LAST_BFLY  = TWI_W'(N_POINTS / 2 - 1);
    localparam logic [STG_W-1:0]  LAST_STAGE = STG_W'(LOG2_N - 1);

    logic [1:0]        state_q;
    logic [1:0]        state_d;
    logic [ADDR_W-1:0] load_cnt_q;
    logic [ADDR_W-1:0] unload_cnt_q;
    logic [ADDR_W-1:0] unload_nxt;
    logic [STG_W-1:0]  stage_q;
    logic [TWI_W-1:0]  bfly_q;
    logic              in_fire;
    logic              out_fire;
    logic              last_bfly;

    logic                     in_ready_q;
    logic                     out_valid_q;
    logic signed [DATA_W-1:0] out_re_q;
    logic signed [DATA_W-1:0] out_im_q;
    logic                     busy_q;
    logic                     done_q;

    // In-place sample store; deliberately not reset.
    logic signed [DATA_W-1:0] mem_re [N_POINTS];
    logic signed [DATA_W-1:0] mem_im [N_POINTS];

    logic        [ADDR_W-1:0] b_ext;
    logic        [ADDR_W-1:0] low;
    logic        [ADDR_W-1:0] addr_p;
    logic        [ADDR_W-1:0] addr_q;
    logic        [TWI_W-1:0]  tw_idx;
    logic signed [TW_W-1:0]   rom_re;
    logic signed [TW_W-1:0]   rom_im;
    logic signed [TW_W-1:0]   w_re;
    logic signed [TW_W-1:0]   w_im;

    logic signed [DATA_W-1:0] xp_re, xp_im, xq_re, xq_im;
    logic signed [MUL_W-1:0]  xq_re_e, xq_im_e, w_re_e, w_im_e;
    logic signed [MUL_W-1:0]  m_re, m_im;
    logic signed [T_W-1:0]    t_re, t_im;
    logic signed [SUM_W-1:0]  s_p_re, s_p_im, s_q_re, s_q_im;
    logic signed [DATA_W-1:0] y_p_re, y_p_im, y_q_re, y_q_im;

    // Handshake qualifiers.
    assign in_fire   = (state_q == LOAD) && bus.in_valid && in_ready_q;
    assign out_fire  = out_valid_q && bus.out_ready;
    assign last_bfly = (stage_q == LAST_STAGE) && (bfly_q == LAST_BFLY);

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = LOAD;
            LOAD:    if (in_fire && (load_cnt_q == LAST_ADDR)) state_d = COMPUTE;
            COMPUTE: if (last_bfly) state_d = UNLOAD;
            UNLOAD:  if (out_fire && (unload_cnt_q == LAST_ADDR)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register and registered control outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d == LOAD);
            out_valid_q <= (state_d == UNLOAD);
            busy_q      <= (state_d != IDLE);
            done_q      <= (state_q == UNLOAD) && (state_d == IDLE);
        end
    end

    // Address of the bin to present next cycle.
    always_comb begin
        unload_nxt = '0;
        if (state_q == UNLOAD) begin
            unload_nxt = out_fire ? (unload_cnt_q + ADDR_W'(1)) : unload_cnt_q;
        end
    end

    // Load, butterfly and unload counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            load_cnt_q   <= '0;
            unload_cnt_q <= '0;
            stage_q      <= '0;
            bfly_q       <= '0;
        end else begin
            if (state_q == IDLE) begin
                load_cnt_q <= '0;
            end else if (in_fire) begin
                load_cnt_q <= load_cnt_q + ADDR_W'(1);
            end
            if (state_q == COMPUTE) begin
                bfly_q <= bfly_q + TWI_W'(1);
                if (bfly_q == LAST_BFLY) begin
                    stage_q <= stage_q + STG_W'(1);
                end
            end else begin
                bfly_q  <= '0;
                stage_q <= '0;
            end
            unload_cnt_q <= unload_nxt;
        end
    end

    // Output bin register; x[0] is never touched by the final butterfly,
    // so reading it on the COMPUTE->UNLOAD edge sees the finished value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_re_q <= '0;
            out_im_q <= '0;
        end else if (state_d == UNLOAD) begin
            out_re_q <= mem_re[unload_nxt];
            out_im_q <= mem_im[unload_nxt];
        end
    end

    // Butterfly addressing and twiddle index for the current (stage, b).
    always_comb begin
        b_ext  = {1'b0, bfly_q};
        low    = b_ext & ((ADDR_W'(1) << stage_q) - ADDR_W'(1));
        addr_p = ((b_ext >> stage_q) << (32'(stage_q) + 32'd1)) | low;
        addr_q = addr_p | (ADDR_W'(1) << stage_q);
        tw_idx = TWI_W'(low << (LOG2_N - 1 - 32'(stage_q)));
    end

    fft_twiddle_rom #(
        .N_POINTS (N_POINTS),
        .LOG2_N   (LOG2_N),
        .TW_W     (TW_W)
    ) u_rom (
        .idx (tw_idx),
        .re  (rom_re),
        .im  (rom_im)
    );

`ifdef FFT_INVERSE_EN
    logic inv_q;

    // Direction is latched with start and held for the whole transform.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inv_q <= 1'b0;
        end else if ((state_q == IDLE) && start) begin
            inv_q <= inv;
        end
    end

    assign w_re = rom_re;
    assign w_im = inv_q ? -rom_im : rom_im;
`else
    assign w_re = rom_re;
    assign w_im = rom_im;
`endif

    // Butterfly datapath: t = x[q]*W, then scaled and saturated sum/difference.
    always_comb begin
        xp_re   = mem_re[addr_p];
        xp_im   = mem_im[addr_p];
        xq_re   = mem_re[addr_q];
        xq_im   = mem_im[addr_q];
        xq_re_e = MUL_W'(xq_re);
        xq_im_e = MUL_W'(xq_im);
        w_re_e  = MUL_W'(w_re);
        w_im_e  = MUL_W'(w_im);
        m_re    = (xq_re_e * w_re_e) - (xq_im_e * w_im_e);
        m_im    = (xq_re_e * w_im_e) + (xq_im_e * w_re_e);
        t_re    = T_W'(m_re >>> (TW_W - 2));
        t_im    = T_W'(m_im >>> (TW_W - 2));
        s_p_re  = SUM_W'(xp_re) + SUM_W'(t_re);
        s_p_im  = SUM_W'(xp_im) + SUM_W'(t_im);
        s_q_re  = SUM_W'(xp_re) - SUM_W'(t_re);
        s_q_im  = SUM_W'(xp_im) - SUM_W'(t_im);
        y_p_re  = DATA_W'(sat(longint'(s_p_re >>> 1), DATA_W));
        y_p_im  = DATA_W'(sat(longint'(s_p_im >>> 1), DATA_W));
        y_q_re  = DATA_W'(sat(longint'(s_q_re >>> 1), DATA_W));
        y_q_im  = DATA_W'(sat(longint'(s_q_im >>> 1), DATA_W));
    end

    // Sample store writes: bit-reversed load, then in-place butterflies.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            mem_re[ADDR_W'(bitrev(32'(load_cnt_q), LOG2_N))] <= bus.in_re;
            mem_im[ADDR_W'(bitrev(32'(load_cnt_q), LOG2_N))] <= bus.in_im;
        end else if (state_q == COMPUTE) begin
            mem_re[addr_p] <= y_p_re;
            mem_im[addr_p] <= y_p_im;
            mem_re[addr_q] <= y_q_re;
            mem_im[addr_q] <= y_q_im;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_re    = out_re_q;
    assign bus.out_im    = out_im_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule

// File: tb/tb_fft_iter_engine.sv
// Directed bench for fft_iter_engine at the default 64-point configuration.
module tb_fft_iter_engine;

    localparam int N = 64;

    typedef struct {
        int test_id;
        int lo;
        int hi;
        int exp_re;
        int exp_im;
        int tol_re;
        int tol_im;
    } vec_t;

    localparam int NTAB = 10;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic busy;
    logic done;
`ifdef FFT_INVERSE_EN
    logic inv = 1'b0;
`endif

    fft_iter_engine_if #(.DATA_W(16)) bus ();

    fft_iter_engine #(
        .N_POINTS (64),
        .LOG2_N   (6),
        .DATA_W   (16),
        .TW_W     (10)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
`ifdef FFT_INVERSE_EN
        .inv   (inv),
`endif
        .busy  (busy),
        .done  (done),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   n_cmp = 0;
    int   n_err = 0;
    int   stim_re [N];
    int   stim_im [N];
    int   res_re [N];
    int   res_im [N];
    vec_t tab [NTAB];

    task automatic chk(input string name, input int act, input int exp, input int tol);
        int d;
        d = act - exp;
        n_cmp++;
        if (d > tol || d < -tol) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d +/- %0d", name, act, exp, tol);
        end
    endtask

    task automatic set_const(input int v0, input int vrest);
        for (int i = 0; i < N; i++) begin
            stim_re[i] = (i == 0) ? v0 : vrest;
            stim_im[i] = 0;
        end
    endtask

    task automatic set_tone();
        real v;
        for (int i = 0; i < N; i++) begin
            v = 8192.0 * $cos(2.0 * 3.14159265358979 * 4.0 * i / 64.0);
            stim_re[i] = (v >= 0.0) ? $rtoi(v + 0.5) : $rtoi(v - 0.5);
            stim_im[i] = 0;
        end
    endtask

    // mode 0 plain, 1 output backpressure, 2 stray start in COMPUTE, 3 reset in COMPUTE
    task automatic run_fft(input int mode);
        int idx;
        int guard;
        int got;
        int stall;
        int t0;
        bit acc;
        logic signed [15:0] hold_re;
        logic signed [15:0] hold_im;
        hold_re = '0;
        hold_im = '0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        start = 1'b1;
        t0 = cyc;
        @(negedge clk);
        start = 1'b0;
        chk("in_ready after start", int'(bus.in_ready), 1, 0);
        chk("busy after start", int'(busy), 1, 0);

        idx = 0;
        guard = 0;
        while (idx < N && guard < 1000) begin
            bus.in_valid = 1'b1;
            bus.in_re = 16'(stim_re[idx]);
            bus.in_im = 16'(stim_im[idx]);
            acc = bus.in_ready;
            @(negedge clk);
            if (acc) idx++;
            guard++;
        end
        bus.in_valid = 1'b0;
        chk("samples loaded", idx, N, 0);

        if (mode == 2) begin
            repeat (20) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            chk("stray start in_ready", int'(bus.in_ready), 0, 0);
            chk("stray start busy", int'(busy), 1, 0);
        end

        if (mode == 3) begin
            repeat (49) @(negedge clk);
            rst = 1'b0;
            #1;
            chk("rst busy", int'(busy), 0, 0);
            chk("rst out_valid", int'(bus.out_valid), 0, 0);
            chk("rst in_ready", int'(bus.in_ready), 0, 0);
            @(negedge clk);
            @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            chk("after rst busy", int'(busy), 0, 0);
            return;
        end

        got = 0;
        stall = 0;
        guard = 0;
        while (got < N && guard < 4000) begin
            if (mode == 1 && got == 5 && stall < 10) begin
                bus.out_ready = 1'b0;
                if (stall == 0) begin
                    hold_re = bus.out_re;
                    hold_im = bus.out_im;
                end else begin
                    chk("stall out_valid", int'(bus.out_valid), 1, 0);
                    chk("stall out_re", int'(bus.out_re), int'(hold_re), 0);
                    chk("stall out_im", int'(bus.out_im), int'(hold_im), 0);
                end
                stall++;
            end else if (bus.out_valid) begin
                bus.out_ready = 1'b1;
                res_re[got] = bus.out_re;
                res_im[got] = bus.out_im;
                got++;
            end
            @(negedge clk);
            guard++;
        end
        chk("bins delivered", got, N, 0);
        chk("done pulse", int'(done), 1, 0);
        if (mode == 0) chk("start-to-done cycles", cyc - t0, 321, 0);
        @(negedge clk);
        chk("done one cycle", int'(done), 0, 0);
        chk("idle busy", int'(busy), 0, 0);
        chk("idle out_valid", int'(bus.out_valid), 0, 0);
    endtask

    task automatic check_table(input int id);
        for (int i = 0; i < NTAB; i++) begin
            if (tab[i].test_id == id) begin
                for (int b = tab[i].lo; b <= tab[i].hi; b++) begin
                    chk($sformatf("t%0d bin%0d re", id, b), res_re[b], tab[i].exp_re, tab[i].tol_re);
                    chk($sformatf("t%0d bin%0d im", id, b), res_im[b], tab[i].exp_im, tab[i].tol_im);
                end
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tab[0] = '{0, 0, 63, 16, 0, 0, 0};
        tab[1] = '{1, 0, 0, 1024, 0, 1, 2};
        tab[2] = '{1, 1, 63, 0, 0, 2, 2};
        tab[3] = '{2, 4, 4, 4096, 0, 4, 4};
        tab[4] = '{2, 60, 60, 4096, 0, 4, 4};
        tab[5] = '{2, 0, 3, 0, 0, 4, 4};
        tab[6] = '{2, 5, 59, 0, 0, 4, 4};
        tab[7] = '{2, 61, 63, 0, 0, 4, 4};
        tab[8] = '{3, 0, 0, 1024, 0, 2, 2};
        tab[9] = '{3, 1, 63, 0, 0, 2, 2};

        bus.in_valid  = 1'b0;
        bus.in_re     = '0;
        bus.in_im     = '0;
        bus.out_ready = 1'b0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset in_ready", int'(bus.in_ready), 0, 0);
        chk("reset out_valid", int'(bus.out_valid), 0, 0);
        chk("reset out_re", int'(bus.out_re), 0, 0);
        chk("reset out_im", int'(bus.out_im), 0, 0);
        chk("reset busy", int'(busy), 0, 0);
        chk("reset done", int'(done), 0, 0);
        rst = 1'b1;
        @(negedge clk);

        set_const(1024, 0);
        run_fft(0);
        check_table(0);

        set_const(1024, 1024);
        run_fft(0);
        check_table(1);

        set_tone();
        run_fft(0);
        check_table(2);

        set_tone();
        run_fft(1);
        check_table(2);

        set_const(1024, 0);
        run_fft(2);
        check_table(0);

        set_const(1024, 1024);
        run_fft(3);
        set_const(1024, 0);
        run_fft(0);
        check_table(0);

`ifdef FFT_INVERSE_EN
        for (int i = 0; i < N; i++) begin
            stim_re[i] = res_re[i] * N;
            stim_im[i] = res_im[i] * N;
        end
        inv = 1'b1;
        run_fft(0);
        inv = 1'b0;
        check_table(3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
